// File: rtl/mulu_x2y2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mulu_x2y2_pkg                                             |
// | Brief    : Shared widths, pin bit-IDs, feature flags and FSM states  |
// |            for the 2x2 unsigned shift-add multiplier.                |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package mulu_x2y2_pkg;

   // Operand and product widths
   localparam int C_X_WIDTH      = 2;
   localparam int C_Y_WIDTH      = 2;
   localparam int C_P_WIDTH      = C_X_WIDTH + C_Y_WIDTH;

   // Pin bus widths and output bit positions
   localparam int C_INPUT_WIDTH  = 8;
   localparam int C_OUTPUT_WIDTH = 8;
   localparam int C_O_P_BITID    = 0;
   localparam int C_O_SIGN_BITID = 6;
   localparam int C_O_READY_BITID = 7;

   // Feature flags: this variant drives a ready strobe and has no sign bit
   localparam bit C_HAS_READY    = 1'b1;
   localparam bit C_HAS_SIGN     = 1'b0;

   // Controller states
   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Iteration counter width; never below one bit so a 1-bit Y still works
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mulu_x2y2_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mulu_x2y2_core                                            |
// | Brief    : Free-running shift-add unsigned multiplier. Samples the   |
// |            operands, adds one shifted partial product per Y bit,     |
// |            then registers the product with a one-cycle ready strobe. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module mulu_x2y2_core
   import mulu_x2y2_pkg::*;
#(
   parameter int X_WIDTH = 2,
   parameter int Y_WIDTH = 2,
   parameter int P_WIDTH = X_WIDTH + Y_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [X_WIDTH-1:0] i_x,
   input  logic [Y_WIDTH-1:0] i_y,
   output logic [P_WIDTH-1:0] o_p,
   output logic               o_rdy
);

   localparam int CNT_W = cnt_width(Y_WIDTH);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [X_WIDTH-1:0] r_xr;
   logic [Y_WIDTH-1:0] r_yr;
   logic [P_WIDTH-1:0] r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic [P_WIDTH-1:0] r_p;
   logic               r_rdy;

   logic               w_last;
   logic [P_WIDTH-1:0] w_x_ext;
   logic [P_WIDTH-1:0] w_addend;
   logic [P_WIDTH-1:0] w_acc_sum;

   // Partial product for the current Y bit; the product width holds the
   // largest result, so the running sum cannot overflow
   assign w_last    = (r_cnt == CNT_W'(Y_WIDTH - 1));
   assign w_x_ext   = {{(P_WIDTH - X_WIDTH){1'b0}}, r_xr};
   assign w_addend  = w_x_ext << r_cnt;
   assign w_acc_sum = r_yr[r_cnt] ? (r_acc + w_addend) : r_acc;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_LOAD;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state: LOAD -> CALC (Y_WIDTH cycles) -> DONE -> LOAD
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_LOAD: w_state_nxt = ST_CALC;
         ST_CALC: if (w_last) w_state_nxt = ST_DONE;
         ST_DONE: w_state_nxt = ST_LOAD;
         default: w_state_nxt = ST_LOAD;
      endcase
   end

   // Datapath and output registers; operands are only captured in LOAD
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_xr  <= '0;
         r_yr  <= '0;
         r_acc <= '0;
         r_cnt <= '0;
         r_p   <= '0;
         r_rdy <= 1'b0;
      end else begin
         case (r_state)
            ST_LOAD: begin
               r_xr  <= i_x;
               r_yr  <= i_y;
               r_acc <= '0;
               r_cnt <= '0;
               r_rdy <= 1'b0;
            end
            ST_CALC: begin
               r_acc <= w_acc_sum;
               r_cnt <= r_cnt + CNT_W'(1);
               r_rdy <= 1'b0;
            end
            ST_DONE: begin
               r_p   <= r_acc;
               r_rdy <= 1'b1;
            end
            default: begin
               r_rdy <= 1'b0;
            end
         endcase
      end
   end

   assign o_p   = r_p;
   assign o_rdy = r_rdy;

endmodule
`default_nettype wire

// File: rtl/mulu_x2y2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mulu_x2y2                                                 |
// | Brief    : 8-in/8-out pin wrapper. Unpacks clock, reset and operands |
// |            from io_in and packs product, sign and ready onto io_out. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module mulu_x2y2
   import mulu_x2y2_pkg::*;
(
   input  logic [C_INPUT_WIDTH-1:0]  io_in,
   output logic [C_OUTPUT_WIDTH-1:0] io_out
);

   logic                 w_clk;
   logic                 w_rst;
   logic [C_X_WIDTH-1:0] w_x;
   logic [C_Y_WIDTH-1:0] w_y;
   logic [C_P_WIDTH-1:0] w_p;
   logic                 w_rdy;
   logic                 w_unused_pins;

   assign w_clk         = io_in[0];
   assign w_rst         = io_in[1];
   assign w_x           = io_in[3:2];
   assign w_y           = io_in[5:4];
   assign w_unused_pins = |io_in[7:6];

   mulu_x2y2_core #(
      .X_WIDTH (C_X_WIDTH),
      .Y_WIDTH (C_Y_WIDTH),
      .P_WIDTH (C_P_WIDTH)
   ) u_core (
      .clk   (w_clk),
      .rst   (w_rst),
      .i_x   (w_x),
      .i_y   (w_y),
      .o_p   (w_p),
      .o_rdy (w_rdy)
   );

   // Pack outputs; all bits not carrying product or ready stay at zero
   always_comb begin
      io_out                                = '0;
      io_out[C_O_P_BITID +: C_P_WIDTH]      = w_p;
      io_out[C_O_SIGN_BITID]                = 1'b0 & C_HAS_SIGN;
      io_out[C_O_READY_BITID]               = w_rdy & C_HAS_READY;
   end

endmodule
`default_nettype wire

// File: tb/tb_mulu_x2y2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_mulu_x2y2                                              |
// | Brief    : Self-checking bench for the 2x2 unsigned multiplier pin   |
// |            wrapper; expected products come from plain x*y.           |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_mulu_x2y2;

   logic       clk;
   logic       rst;
   logic [1:0] x;
   logic [1:0] y;
   logic [7:0] io_in;
   logic [7:0] io_out;

   int         vectors;
   int         miscompares;
   logic [3:0] prev_p;

   assign io_in = {2'b00, y, x, rst, clk};

   mulu_x2y2 dut (
      .io_in  (io_in),
      .io_out (io_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full transaction: operands presented before the sampling edge,
   // optionally scrambled after it; three quiet edges then the ready edge
   task automatic do_op(input logic [1:0] a, input logic [1:0] b, input bit scramble);
      logic [3:0] expv;
      expv = 4'(int'(a) * int'(b));
      x = a;
      y = b;
      tick();
      chk("load_hold", io_out, {4'b0000, prev_p});
      if (scramble) begin
         x = 2'($urandom);
         y = 2'($urandom);
      end
      tick();
      chk("calc1_hold", io_out, {4'b0000, prev_p});
      if (scramble) begin
         x = 2'($urandom);
         y = 2'($urandom);
      end
      tick();
      chk("calc2_hold", io_out, {4'b0000, prev_p});
      tick();
      chk($sformatf("done_%0dx%0d", a, b), io_out, {4'b1000, expv});
      prev_p = expv;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      prev_p      = 4'd0;
      rst         = 1'b1;
      x           = 2'd0;
      y           = 2'd0;

      // Reset state
      tick();
      tick();
      chk("reset_out", io_out, 8'h00);
      #2 rst = 1'b0;

      // Directed cases
      do_op(2'd3, 2'd3, 1'b0);
      do_op(2'd2, 2'd1, 1'b0);
      do_op(2'd1, 2'd2, 1'b0);
      do_op(2'd0, 2'd3, 1'b0);
      do_op(2'd3, 2'd0, 1'b0);

      // Operands changing while in flight, then zero operands
      do_op(2'd3, 2'd3, 1'b1);
      do_op(2'd0, 2'd0, 1'b0);

      // Exhaustive back-to-back
      for (int i = 0; i < 16; i++) begin
         do_op(2'(i >> 2), 2'(i), 1'b0);
      end

      // Random operands with random in-flight disturbance
      for (int i = 0; i < 24; i++) begin
         do_op(2'($urandom), 2'($urandom), 1'($urandom));
      end

      // Asynchronous reset in the middle of a calculation
      x = 2'd3;
      y = 2'd2;
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      chk("rst_async", io_out, 8'h00);
      tick();
      chk("rst_held", io_out, 8'h00);
      #2 rst = 1'b0;
      prev_p = 4'd0;

      // First strobe after release at the 4th edge
      do_op(2'd2, 2'd3, 1'b0);
      do_op(2'd1, 2'd1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
